// File: rtl/bomb_controller_if.sv
// rtl/bomb_controller_if.sv - puzzle-module bus between the bomb controller and its modules
interface bomb_controller_if #(
    parameter int NUM_MODULES = 4
);
    logic                   start;
    logic [NUM_MODULES-1:0] strike;
    logic [NUM_MODULES-1:0] module_defused;
    logic                   module_enable;
    logic [9:0]             seconds_left;
    logic [1:0]             strikes;
    logic                   tick;
    logic                   armed;
    logic                   defused;
    logic                   exploded;

    modport master (
        output start, strike, module_defused,
        input  module_enable, seconds_left, strikes, tick, armed, defused, exploded
    );

    modport slave (
        input  start, strike, module_defused,
        output module_enable, seconds_left, strikes, tick, armed, defused, exploded
    );
endinterface

// File: rtl/bomb_controller.sv
// rtl/bomb_controller.sv - game FSM: arming, countdown, strike tally, defuse/explode decision
// Optional STRIKE_SPEEDUP_EN: each accumulated strike halves the length of a countdown second.
module bomb_controller #(
    parameter int NUM_MODULES   = 4,
    parameter int CLK_HZ        = 27000000,
    parameter int START_SECONDS = 300,
    parameter int MAX_STRIKES   = 3
) (
    input  logic               clock,
    input  logic               reset,
    bomb_controller_if.slave   bus
);
    localparam int         PW    = $clog2(CLK_HZ + 1);
    localparam logic [1:0] MAX_S = 2'(MAX_STRIKES);

    typedef enum logic [1:0] {IDLE, ARMED, DEFUSED, EXPLODED} state_t;

    state_t                 state;
    logic [PW-1:0]          prescaler;
    logic [PW-1:0]          terminal;
    logic [NUM_MODULES-1:0] strike_q;
    logic [NUM_MODULES-1:0] strike_edge;
    int                     edge_count;
    int                     strike_sum;
    logic [1:0]             strikes_new;
    logic                   second_done;
    logic [9:0]             seconds_new;
    logic                   blow_up;

    always_comb begin
        strike_edge = bus.strike & ~strike_q;
        edge_count  = 0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            edge_count = edge_count + int'(strike_edge[i]);
        end
        strike_sum  = int'(bus.strikes) + edge_count;
        strikes_new = (strike_sum >= MAX_STRIKES) ? MAX_S : 2'(strike_sum);

`ifdef STRIKE_SPEEDUP_EN
        // Uses the registered strike count; a lowered terminal below the
        // running prescaler fires on the next edge thanks to the >= compare.
        terminal = PW'((CLK_HZ >> bus.strikes) - 1);
`else
        terminal = PW'(CLK_HZ - 1);
`endif
        second_done = (prescaler >= terminal);
        seconds_new = second_done ? (bus.seconds_left - 10'd1) : bus.seconds_left;
        blow_up     = (strikes_new >= MAX_S) || (seconds_new == 10'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            prescaler         <= '0;
            strike_q          <= '0;
            bus.seconds_left  <= 10'(START_SECONDS);
            bus.strikes       <= 2'd0;
            bus.tick          <= 1'b0;
            bus.module_enable <= 1'b0;
            bus.armed         <= 1'b0;
            bus.defused       <= 1'b0;
            bus.exploded      <= 1'b0;
        end else begin
            // Tracking every cycle means lines already high at arming never count.
            strike_q <= bus.strike;
            bus.tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state             <= ARMED;
                        bus.seconds_left  <= 10'(START_SECONDS);
                        bus.strikes       <= 2'd0;
                        prescaler         <= '0;
                        bus.armed         <= 1'b1;
                        bus.module_enable <= 1'b1;
                    end
                end
                ARMED: begin
                    prescaler        <= second_done ? '0 : prescaler + PW'(1);
                    bus.seconds_left <= seconds_new;
                    bus.tick         <= second_done;
                    bus.strikes      <= strikes_new;
                    if (blow_up) begin
                        state             <= EXPLODED;
                        bus.armed         <= 1'b0;
                        bus.module_enable <= 1'b0;
                        bus.exploded      <= 1'b1;
                    end else if (&bus.module_defused) begin
                        state             <= DEFUSED;
                        bus.armed         <= 1'b0;
                        bus.module_enable <= 1'b0;
                        bus.defused       <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bomb_controller.sv
// tb/tb_bomb_controller.sv - directed self-checking bench for bomb_controller
module tb_bomb_controller;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    bomb_controller_if #(.NUM_MODULES(4)) bus ();

    bomb_controller #(
        .NUM_MODULES  (4),
        .CLK_HZ       (8),
        .START_SECONDS(3),
        .MAX_STRIKES  (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_armed"},    32'(bus.armed), 0);
        check({tag, "_enable"},   32'(bus.module_enable), 0);
        check({tag, "_defused"},  32'(bus.defused), 0);
        check({tag, "_exploded"}, 32'(bus.exploded), 0);
        check({tag, "_tick"},     32'(bus.tick), 0);
        check({tag, "_seconds"},  32'(bus.seconds_left), 3);
        check({tag, "_strikes"},  32'(bus.strikes), 0);
    endtask

    task automatic do_reset();
        bus.start          = 1'b0;
        bus.strike         = 4'b0000;
        bus.module_defused = 4'b0000;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic arm();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("arm_armed",  32'(bus.armed), 1);
        check("arm_enable", 32'(bus.module_enable), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.start          = 1'b0;
        bus.strike         = 4'b0000;
        bus.module_defused = 4'b0000;
        reset = 1'b1;
        #12;
        reset = 1'b0;
        step();
        check_reset_values("reset");

        // Timeout: ticks at 8/16/24, explode on the last one
        arm();
        for (int c = 1; c <= 24; c++) begin
            step();
            check($sformatf("to_tick_c%0d", c), 32'(bus.tick), (c % 8 == 0) ? 1 : 0);
            check($sformatf("to_sec_c%0d", c), 32'(bus.seconds_left), 32'(3 - c / 8));
            if (c == 23) check("to_not_yet", 32'(bus.exploded), 0);
        end
        check("to_exploded", 32'(bus.exploded), 1);
        check("to_enable",   32'(bus.module_enable), 0);
        check("to_armed",    32'(bus.armed), 0);
        step();
        check("to_frozen_tick", 32'(bus.tick), 0);
        check("to_frozen_sec",  32'(bus.seconds_left), 0);

        // Defuse, then terminal state ignores start and strikes
        do_reset();
        step();
        arm();
        repeat (5) step();
        bus.module_defused = 4'b1111;
        check("df_pre", 32'(bus.defused), 0);
        step();
        check("df_defused", 32'(bus.defused), 1);
        check("df_armed",   32'(bus.armed), 0);
        check("df_enable",  32'(bus.module_enable), 0);
        check("df_seconds", 32'(bus.seconds_left), 3);
        bus.start  = 1'b1;
        bus.strike = 4'b1111;
        step();
        bus.start  = 1'b0;
        bus.strike = 4'b0000;
        repeat (10) step();
        check("df_hold",     32'(bus.defused), 1);
        check("df_nostrike", 32'(bus.strikes), 0);
        check("df_noarm",    32'(bus.armed), 0);
        check("df_seconds2", 32'(bus.seconds_left), 3);

        // Simultaneous strikes count individually
        do_reset();
        step();
        arm();
        bus.strike = 4'b0101;
        step();
        bus.strike = 4'b0000;
        check("ss_two",     32'(bus.strikes), 2);
        check("ss_alive",   32'(bus.exploded), 0);
        step();
        bus.strike = 4'b0010;
        step();
        bus.strike = 4'b0000;
        check("ss_three",   32'(bus.strikes), 3);
        check("ss_exploded", 32'(bus.exploded), 1);
        check("ss_armed",   32'(bus.armed), 0);

        // Explosion beats defuse; four edges saturate at three
        do_reset();
        step();
        arm();
        bus.strike         = 4'b1111;
        bus.module_defused = 4'b1111;
        step();
        bus.strike         = 4'b0000;
        bus.module_defused = 4'b0000;
        check("pr_exploded", 32'(bus.exploded), 1);
        check("pr_defused",  32'(bus.defused), 0);
        check("pr_saturate", 32'(bus.strikes), 3);

        // A line already high at arming is not a strike
        do_reset();
        bus.strike = 4'b0001;
        repeat (2) step();
        arm();
        repeat (3) step();
        check("hh_none", 32'(bus.strikes), 0);
        bus.strike = 4'b0000;
        step();
        bus.strike = 4'b0001;
        step();
        check("hh_one", 32'(bus.strikes), 1);
        bus.strike = 4'b0000;

        // Strike effect on second length, then async reset mid-cycle
        do_reset();
        step();
        arm();
        step();
        bus.strike = 4'b0001;
        step();
        bus.strike = 4'b0000;
        check("sp_strike", 32'(bus.strikes), 1);
        for (int c = 3; c <= 8; c++) begin
            step();
`ifdef STRIKE_SPEEDUP_EN
            check($sformatf("sp_tick_c%0d", c), 32'(bus.tick), (c == 4 || c == 8) ? 1 : 0);
`else
            check($sformatf("sp_tick_c%0d", c), 32'(bus.tick), (c == 8) ? 1 : 0);
`endif
        end
`ifdef STRIKE_SPEEDUP_EN
        check("sp_seconds", 32'(bus.seconds_left), 1);
`else
        check("sp_seconds", 32'(bus.seconds_left), 2);
`endif
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        reset = 1'b0;
        step();
        check_reset_values("post_async");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bomb_controller.md
# bomb_controller

Top-level game controller sitting directly downstream of the puzzle modules (keypad and siblings). It arms the bomb on a start request and enables every module while armed. It runs the countdown timer from the 27 MHz clock and tallies strike pulses from all modules. It declares the bomb defused when every module reports defused, or exploded on timeout or too many strikes.

## Interface
- `NUM_MODULES`, default 4: number of puzzle modules attached.
- `CLK_HZ`, default 27000000: clock cycles per countdown second (prescaler terminal count + 1).
- `START_SECONDS`, default 300: countdown load value; must fit in 10 bits.
- `MAX_STRIKES`, default 3: strike count that detonates; range 1..3.
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  arm request; sampled only in IDLE.
- `strike`  in  NUM_MODULES  per-module strike lines; rising edge = one strike.
- `module_defused`  in  NUM_MODULES  per-module defused levels.
- `module_enable`  out  1  fans out to every module's `enable`; high only in ARMED.
- `seconds_left`  out  10  remaining whole seconds.
- `strikes`  out  2  strikes accumulated, saturating at MAX_STRIKES.
- `tick`  out  1  one-cycle pulse on each seconds decrement.
- `armed`, `defused`, `exploded`  out  1 each  one-hot state flags (all low in IDLE).

## Operation
- FSM states: IDLE, ARMED, DEFUSED, EXPLODED. All outputs are registered.
- Reset values: state IDLE, `seconds_left`=START_SECONDS, `strikes`=0, prescaler=0, strike edge register=0, all 1-bit outputs 0.
- **IDLE**
  - `start`=1: go to ARMED.
  - On that edge, load `seconds_left`=START_SECONDS, clear `strikes` and the prescaler, and capture current `strike` into the edge register so that already-high lines do not count.
- **ARMED**
  - Prescaler increments each cycle.
  - When the prescaler ≥ terminal (CLK_HZ−1 by default): the prescaler clears, `seconds_left` decrements and `tick` pulses.
- **Strike counting**
  - strike edge = `strike & ~strike_q`, where `strike_q` is the previous-cycle value.
  - `strikes` += popcount(edges), saturating at MAX_STRIKES; simultaneous edges from different modules each count.
- **Exit conditions from ARMED**, evaluated on the same edge as the updates above:
  - Go to EXPLODED if the new `strikes` ≥ MAX_STRIKES, or if the new `seconds_left` = 0.
  - Otherwise go to DEFUSED if `module_defused` is all ones.
  - Explosion has priority over defuse in the same cycle.
- **DEFUSED / EXPLODED**
  - Terminal states; counters are frozen and `start` is ignored.
  - Only `reset` leaves them.
- Strikes and `module_defused` are ignored outside ARMED.

## Timing
- `start` sampled at edge n: `armed`=1 and `module_enable`=1 after edge n.
- First `tick` occurs CLK_HZ cycles after arming; it then repeats every CLK_HZ cycles.
- Strike rising edge present before edge n: `strikes` is updated after edge n, with one cycle of latency.
- A detonating strike or the final tick drives `exploded` high after the same edge; `armed` and `module_enable` drop on that edge.
- Defuse: `defused` goes high one edge after `module_defused` is all ones.
- Asynchronous reset mid-operation returns to the reset values immediately, independent of `clock`.

## Configuration
- `STRIKE_SPEEDUP_EN` defined:
  - Prescaler terminal becomes (CLK_HZ >> `strikes`) − 1, so each strike halves the second length.
  - The ≥ compare means a strike that lowers the terminal below the current prescaler value ticks on the next edge.
- `STRIKE_SPEEDUP_EN` undefined: terminal is fixed at CLK_HZ−1 and strikes do not affect timing.

## Test plan
- Bench settings: CLK_HZ=8, START_SECONDS=3, NUM_MODULES=4, MAX_STRIKES=3.
- **Timeout:** reset, pulse `start` → `armed` next cycle; `tick` at cycles 8, 16, 24; `seconds_left` goes 3→2→1→0; `exploded`=1 at cycle 24 and `module_enable`=0.
- **Defuse:** arm, raise `module_defused`=4'b1111 at cycle 5 → `defused`=1 at cycle 6; `seconds_left` stays 3; later `start` and strikes have no effect.
- **Simultaneous strikes:** arm, then one-cycle `strike`=4'b0101 → `strikes`=2; a further one-cycle pulse on bit 1 → `strikes`=3 and `exploded`=1 the same cycle.
- **Priority:** in the cycle `strikes` reaches 3, also drive `module_defused`=4'b1111 → `exploded`=1 and `defused`=0.
- **Held-high strike:** `strike[0]` already high in IDLE, then `start` → no strike counted; a later drop and re-rise counts 1.
- **Speedup with `STRIKE_SPEEDUP_EN`:** one strike at cycle 2 → next ticks at cycles 4, 8, 12 (period 4); reset at cycle 9 → all outputs return to reset values immediately.
